// File: rtl/top_addrmap_pkg.sv
// TOP address map: base/size of the TOP register window, STATUS slot count and slot state type.
package top_addrmap_pkg;

  localparam logic [63:0] TOP_BASE_ADDR  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] TOP_SIZE       = 64'h0000_0000_0000_0008;
  localparam int unsigned TOP_STATUS_NUM = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One 32-bit word per STATUS slot, packed from the base of the window.
  function automatic logic [63:0] TOP_STATUS_BASE_ADDR(input int unsigned idx);
    return TOP_BASE_ADDR + 64'(idx) * 64'd4;
  endfunction

endpackage

// File: rtl/top_status_ctrl_pkg.sv
// Block-local types for the TOP status controller: slot and client index widths.
package top_status_ctrl_pkg;

  import top_addrmap_pkg::*;

  localparam int unsigned NUM_CLIENTS  = 2;
  localparam int unsigned SLOT_IDX_W   = (TOP_STATUS_NUM > 1) ? $clog2(TOP_STATUS_NUM) : 1;
  localparam int unsigned CLIENT_IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef logic [SLOT_IDX_W-1:0]   slot_idx_t;
  typedef logic [CLIENT_IDX_W-1:0] client_idx_t;

endpackage

// File: rtl/top_status_rr_arb.sv
// Round-robin arbiter: one-hot grant among requesters, searched from the pointer;
// the pointer moves past the winner only when the grant is enabled.
module top_status_rr_arb
  import top_status_ctrl_pkg::*;
#(
  parameter int unsigned NumClients = NUM_CLIENTS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumClients-1:0] req_i,
  input  logic                  en_i,
  output logic [NumClients-1:0] gnt_o
);

  localparam int unsigned IdxW = (NumClients > 1) ? $clog2(NumClients) : 1;

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_winner;
  logic            w_found;
  int unsigned     w_idx;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned i = 0; i < NumClients; i++) begin
      w_idx = (32'(r_ptr) + i) % NumClients;
      if (!w_found && req_i[IdxW'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = IdxW'(w_idx);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (en_i && w_found) begin
      gnt_o[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (en_i && w_found) begin
      r_ptr <= (32'(w_winner) == NumClients - 1) ? '0 : w_winner + 1'b1;
    end
  end

endmodule

// File: rtl/top_status_ctrl.sv
// TOP STATUS slot owner: hardware allocate/free of IDLE/BUSY slots plus
// software read/write of the same slots over a single-outstanding register bus.
module top_status_ctrl
  import top_addrmap_pkg::*;
  import top_status_ctrl_pkg::*;
#(
  parameter int unsigned NumSlots   = TOP_STATUS_NUM,
  parameter int unsigned NumClients = NUM_CLIENTS,
  parameter int unsigned AddrWidth  = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumClients-1:0]       alloc_valid_i,
  output logic [NumClients-1:0]       alloc_ready_o,
  output logic [$clog2(NumSlots)-1:0] alloc_slot_o,
  input  logic [NumSlots-1:0]         free_i,
  output logic [NumSlots-1:0]         slot_busy_o,
  input  logic                        reg_req_valid_i,
  output logic                        reg_req_ready_o,
  input  logic                        reg_req_write_i,
  input  logic [AddrWidth-1:0]        reg_req_addr_i,
  input  logic [31:0]                 reg_req_wdata_i,
  output logic                        reg_rsp_valid_o,
  input  logic                        reg_rsp_ready_i,
  output logic [31:0]                 reg_rsp_rdata_o,
  output logic                        reg_rsp_error_o
);

  localparam int unsigned SlotW = $clog2(NumSlots);

  state_e              r_state [NumSlots];
  state_e              w_state_d [NumSlots];
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_error;

  logic                w_any_idle;
  logic [SlotW-1:0]    w_free_slot;
  logic                w_req_fire;
  logic [AddrWidth-1:0] w_off;
  logic                w_in_range;
  logic [NumSlots-1:0] w_slot_hit;
  logic [SlotW-1:0]    w_bus_idx;
  logic                w_hit;
  logic                w_bus_wr;
  logic                w_grant_en;
  logic                w_grant;
  logic                w_rd_bit;
  logic                w_unused_wdata;

  assign w_unused_wdata = |reg_req_wdata_i[31:1];

  // Lowest-index IDLE slot is the allocation candidate.
  always_comb begin
    w_any_idle  = 1'b0;
    w_free_slot = '0;
    for (int k = NumSlots - 1; k >= 0; k--) begin
      if (r_state[k] == IDLE) begin
        w_any_idle  = 1'b1;
        w_free_slot = SlotW'(k);
      end
    end
  end

  assign reg_req_ready_o = !r_rsp_valid;
  assign w_req_fire      = reg_req_valid_i && reg_req_ready_o;

  // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
  assign w_off      = reg_req_addr_i - AddrWidth'(TOP_BASE_ADDR);
  assign w_in_range = (w_off < AddrWidth'(TOP_SIZE)) && (reg_req_addr_i[1:0] == 2'b00);

  always_comb begin
    w_slot_hit = '0;
    w_bus_idx  = '0;
    for (int unsigned k = 0; k < NumSlots; k++) begin
      if (reg_req_addr_i == AddrWidth'(TOP_STATUS_BASE_ADDR(k))) begin
        w_slot_hit[k] = 1'b1;
        w_bus_idx     = SlotW'(k);
      end
    end
  end

  assign w_hit    = w_in_range && (|w_slot_hit);
  assign w_bus_wr = w_req_fire && reg_req_write_i && w_hit;

  // A bus write to the candidate slot wins; the grant and pointer step are held off.
  assign w_grant_en = w_any_idle && !(w_bus_wr && (w_bus_idx == w_free_slot));

  top_status_rr_arb #(
    .NumClients (NumClients)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (alloc_valid_i),
    .en_i   (w_grant_en),
    .gnt_o  (alloc_ready_o)
  );

  assign w_grant      = |alloc_ready_o;
  assign alloc_slot_o = w_free_slot;

  // Per-slot update, priority: bus write, then free, then grant.
  always_comb begin
    for (int unsigned k = 0; k < NumSlots; k++) begin
      w_state_d[k] = r_state[k];
      if (w_bus_wr && (w_bus_idx == SlotW'(k))) begin
        w_state_d[k] = reg_req_wdata_i[0] ? BUSY : IDLE;
      end else if (free_i[k]) begin
        w_state_d[k] = IDLE;
      end else if (w_grant && (w_free_slot == SlotW'(k))) begin
        w_state_d[k] = BUSY;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumSlots; k++) begin
        r_state[k] <= IDLE;
      end
    end else begin
      for (int unsigned k = 0; k < NumSlots; k++) begin
        r_state[k] <= w_state_d[k];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NumSlots; k++) begin
      slot_busy_o[k] = (r_state[k] == BUSY);
    end
  end

  assign w_rd_bit = (r_state[w_bus_idx] == BUSY);

  // Response captured at accept and held until consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else if (w_req_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_error <= !w_hit;
      r_rsp_rdata <= (w_hit && !reg_req_write_i) ? {31'b0, w_rd_bit} : 32'h0;
    end else if (r_rsp_valid && reg_rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign reg_rsp_valid_o = r_rsp_valid;
  assign reg_rsp_rdata_o = r_rsp_rdata;
  assign reg_rsp_error_o = r_rsp_error;

endmodule

// File: tb/tb_top_status_ctrl.sv
// Bench for top_status_ctrl: directed scenarios plus random traffic, each cycle
// checked against a slot/pointer/response model built from the block's rules.
module tb_top_status_ctrl;
  import top_addrmap_pkg::*;

  localparam int unsigned NS = TOP_STATUS_NUM;
  localparam int unsigned NC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] alloc_valid;
  logic [NC-1:0] alloc_ready;
  logic [$clog2(NS)-1:0] alloc_slot;
  logic [NS-1:0] free_v;
  logic [NS-1:0] slot_busy;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [63:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;

  always #5 clk = ~clk;

  top_status_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .alloc_valid_i   (alloc_valid),
    .alloc_ready_o   (alloc_ready),
    .alloc_slot_o    (alloc_slot),
    .free_i          (free_v),
    .slot_busy_o     (slot_busy),
    .reg_req_valid_i (req_valid),
    .reg_req_ready_o (req_ready),
    .reg_req_write_i (req_write),
    .reg_req_addr_i  (req_addr),
    .reg_req_wdata_i (req_wdata),
    .reg_rsp_valid_o (rsp_valid),
    .reg_rsp_ready_i (rsp_ready),
    .reg_rsp_rdata_o (rsp_rdata),
    .reg_rsp_error_o (rsp_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [NS-1:0] m_busy;
  int            m_ptr;
  logic          m_rsp_v;
  logic          m_rsp_w;
  logic [31:0]   m_rsp_d;
  logic          m_rsp_e;
  logic [NC-1:0] m_want;
  int            exp_win;

  // Last observed DUT values, for directed checks against fixed expectations
  logic [NC-1:0] obs_gnt;
  logic [63:0]   obs_slot;
  logic [NS-1:0] obs_busy;
  logic          obs_rsp_v;
  logic [31:0]   obs_rdata;
  logic          obs_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'h4;
      2:       return 64'h8;
      3:       return 64'h2;
      4:       return 64'h9;
      5:       return 64'hC;
      6:       return 64'h1_0000_0004;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One clock: drive at negedge, check settled outputs, then advance the model.
  task automatic step(input logic [NC-1:0] av, input logic [NS-1:0] fr, input logic rv,
                      input logic rw, input logic [63:0] ra, input logic [31:0] wd,
                      input logic rr);
    int lowest, win, widx, c;
    logic fire, hit, wr;
    logic [63:0] off;
    logic [NS-1:0] nb;
    logic [NC-1:0] eg;
    @(negedge clk);
    alloc_valid = av; free_v = fr; req_valid = rv; req_write = rw;
    req_addr = ra; req_wdata = wd; rsp_ready = rr;
    #1;
    obs_gnt = alloc_ready; obs_slot = 64'(alloc_slot); obs_busy = slot_busy;
    obs_rsp_v = rsp_valid; obs_rdata = rsp_rdata; obs_err = rsp_error;

    lowest = -1;
    for (int s = 0; s < int'(NS); s++) if (!m_busy[s] && lowest < 0) lowest = s;
    fire = rv && !m_rsp_v;
    off  = ra - TOP_BASE_ADDR;
    hit  = (off < TOP_SIZE) && (ra % 64'd4 == 64'd0) && (off / 64'd4 < 64'(NS));
    widx = hit ? int'(off / 64'd4) : 0;
    wr   = fire && rw && hit;
    win  = -1;
    if (lowest >= 0 && !(wr && widx == lowest)) begin
      for (int i = 0; i < int'(NC); i++) begin
        c = (m_ptr + i) % NC;
        if (av[c] && win < 0) win = c;
      end
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    exp_win = win;

    chk("alloc_ready", 64'(obs_gnt), 64'(eg));
    if (win >= 0) chk("alloc_slot", obs_slot, 64'(lowest));
    chk("slot_busy", 64'(obs_busy), 64'(m_busy));
    chk("req_ready", 64'(req_ready), 64'(!m_rsp_v));
    chk("rsp_valid", 64'(obs_rsp_v), 64'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_error", 64'(obs_err), 64'(m_rsp_e));
      if (!m_rsp_w || m_rsp_e) chk("rsp_rdata", 64'(obs_rdata), 64'(m_rsp_d));
    end

    nb = m_busy;
    if (win >= 0) nb[lowest] = 1'b1;
    for (int s = 0; s < int'(NS); s++) if (fr[s]) nb[s] = 1'b0;
    if (wr) nb[widx] = wd[0];
    if (win >= 0) m_ptr = (win + 1) % NC;
    if (fire) begin
      m_rsp_v = 1'b1;
      m_rsp_w = rw;
      m_rsp_e = !hit;
      m_rsp_d = (hit && !rw) ? {31'b0, m_busy[widx]} : 32'h0;
    end else if (m_rsp_v && rr) begin
      m_rsp_v = 1'b0;
    end
    m_busy = nb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    alloc_valid = '0; free_v = '0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_alloc_ready", 64'(alloc_ready), 64'h0);
    chk("rst_alloc_slot", 64'(alloc_slot), 64'h0);
    chk("rst_slot_busy", 64'(slot_busy), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    chk("rst_rsp_error", 64'(rsp_error), 64'h0);
    m_busy = '0; m_ptr = 0; m_rsp_v = 1'b0; m_rsp_w = 1'b0;
    m_rsp_d = '0; m_rsp_e = 1'b0; m_want = '0; exp_win = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [63:0] dec_addr [3];
  logic        dec_wr   [3];

  initial begin
    rst_n = 1'b1;
    dec_addr[0] = 64'h8; dec_wr[0] = 1'b0;
    dec_addr[1] = 64'h2; dec_wr[1] = 1'b0;
    dec_addr[2] = 64'h9; dec_wr[2] = 1'b1;

    // Allocate to saturation
    do_reset();
    step(2'b11, '0, 0, 0, 64'h0, 32'h0, 1);
    chk("sat_gnt0", 64'(obs_gnt), 64'b01);
    chk("sat_slot0", obs_slot, 64'd0);
    step(2'b10, '0, 0, 0, 64'h0, 32'h0, 1);
    chk("sat_gnt1", 64'(obs_gnt), 64'b10);
    chk("sat_slot1", obs_slot, 64'd1);
    step(2'b01, '0, 0, 0, 64'h0, 32'h0, 1);
    chk("sat_no_gnt", 64'(obs_gnt), 64'b00);
    chk("sat_busy", 64'(obs_busy), 64'b11);

    // Round-robin fairness with every busy slot freed each cycle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(2'b11, m_busy, 0, 0, 64'h0, 32'h0, 1);
      chk("rr_alternate", 64'(obs_gnt), (i % 2 == 0) ? 64'b01 : 64'b10);
    end

    // Bus write then read of slot 1
    do_reset();
    step('0, '0, 1, 1, 64'h4, 32'h1, 0);
    step('0, '0, 0, 0, 64'h0, 32'h0, 1);
    chk("wr_busy1", 64'(obs_busy[1]), 64'd1);
    chk("wr_error", 64'(obs_err), 64'd0);
    step('0, '0, 1, 0, 64'h4, 32'h0, 0);
    step('0, '0, 0, 0, 64'h0, 32'h0, 1);
    chk("rd_valid", 64'(obs_rsp_v), 64'd1);
    chk("rd_rdata", 64'(obs_rdata), 64'h1);
    chk("rd_error", 64'(obs_err), 64'd0);

    // Decode errors leave state untouched
    for (int i = 0; i < 3; i++) begin
      step('0, '0, 1, dec_wr[i], dec_addr[i], 32'h1, 0);
      step('0, '0, 0, 0, 64'h0, 32'h0, 1);
      chk("dec_error", 64'(obs_err), 64'd1);
      chk("dec_rdata", 64'(obs_rdata), 64'h0);
      chk("dec_busy", 64'(obs_busy), 64'b10);
    end

    // Bus write vs free vs grant on slot 0
    do_reset();
    step(2'b01, 2'b01, 1, 1, 64'h0, 32'h0, 1);
    chk("col_gnt_suppressed", 64'(obs_gnt), 64'b00);
    step(2'b11, '0, 0, 0, 64'h0, 32'h0, 1);
    chk("col_slot0_idle", 64'(obs_busy[0]), 64'd0);
    chk("col_ptr_kept", 64'(obs_gnt), 64'b01);

    // Reset with a pending response and busy slots
    do_reset();
    step(2'b11, '0, 0, 0, 64'h0, 32'h0, 1);
    step(2'b10, '0, 0, 0, 64'h0, 32'h0, 1);
    step('0, '0, 1, 0, 64'h0, 32'h0, 0);
    step('0, '0, 0, 0, 64'h0, 32'h0, 0);
    chk("pre_rst_pending", 64'(obs_rsp_v), 64'd1);
    do_reset();
    step(2'b10, '0, 0, 0, 64'h0, 32'h0, 1);
    chk("post_rst_gnt", 64'(obs_gnt), 64'b10);
    chk("post_rst_slot", obs_slot, 64'd0);

    // Random traffic; clients hold their request until granted
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      m_want = m_want | NC'($urandom);
      step(m_want, NS'($urandom & $urandom) & m_busy, ($urandom % 3) == 0,
           1'($urandom), pick_addr(), $urandom, ($urandom % 4) != 0);
      if (exp_win >= 0) m_want[exp_win] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/top_status_ctrl.md
# top_status_ctrl

Owner of the TOP status register array: holds one `state_e` (IDLE/BUSY) per STATUS slot, allocates free slots to hardware clients via a round-robin arbiter, and serves software reads/writes of the same slots over a simple register-bus slave port. Sits between the generated `top_addrmap_pkg` address map and the client engines that claim and free status slots.

## Interface
- NumSlots, default `TOP_STATUS_NUM` (2): number of STATUS slots.
- NumClients, default 2: number of hardware requesters.
- AddrWidth, default 64: register-bus address width.
- Clock/reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- alloc_valid_i  in  NumClients  per-client slot request.
- alloc_ready_o  out  NumClients  per-client grant; one-hot or zero.
- alloc_slot_o  out  $clog2(NumSlots)  granted slot index, valid with any alloc_ready_o bit.
- free_i  in  NumSlots  per-slot release pulse from the hardware side.
- slot_busy_o  out  NumSlots  current state per slot (1 = BUSY).
- reg_req_valid_i  in  1  bus request valid.
- reg_req_ready_o  out  1  bus request accepted.
- reg_req_write_i  in  1  1 = write, 0 = read.
- reg_req_addr_i  in  AddrWidth  byte address.
- reg_req_wdata_i  in  32  write data; only bit 0 used.
- reg_rsp_valid_o  out  1  response valid.
- reg_rsp_ready_i  in  1  response consumed.
- reg_rsp_rdata_o  out  32  read data, `{31'b0, state}`.
- reg_rsp_error_o  out  1  decode error.

## Operation
- Slot state: IDLE or BUSY (`state_e`). Reset: all IDLE.
- Allocation: a grant is issued only when at least one slot is IDLE and at least one client is requesting. The lowest-index IDLE slot is granted. Arbitration is round-robin among requesting clients. The pointer moves to the client after the winner. At most one grant per cycle. The granted slot becomes BUSY the next cycle.
- Release: `free_i[k]` makes slot k IDLE the next cycle. `free_i` on an IDLE slot has no effect. A slot released in cycle t is not grantable in cycle t.
- Bus decode: the address hits when it lies in `[TOP_BASE_ADDR, TOP_BASE_ADDR+TOP_SIZE)` and `addr[1:0]==0`. The slot index is `(addr-TOP_BASE_ADDR)>>2`, which must also be < NumSlots.
- Miss: `error=1`, `rdata=0`, no state change.
- Bus write: `wdata[0]=1` sets the slot to BUSY; `wdata[0]=0` sets it to IDLE (software abort/reserve).
- Bus read: returns the slot state as sampled in the accept cycle.
- Same-cycle collisions on one slot, highest priority first: bus write, then `free_i`, then grant. A grant targeting a slot hit by a bus write is suppressed: `alloc_ready_o=0` that cycle and the pointer does not move.

## Timing
- Reset values: `alloc_ready_o=0`, `alloc_slot_o=0`, `slot_busy_o=0`, `reg_req_ready_o=1`, `reg_rsp_valid_o=0`, `reg_rsp_rdata_o=0`, `reg_rsp_error_o=0`, RR pointer=0.
- Grant is combinational from `alloc_valid_i` and the registered state. The client must hold `alloc_valid_i` until granted.
- Bus: a request is accepted when valid and ready are both high. The response is valid exactly 1 cycle later.
- `reg_req_ready_o = !reg_rsp_valid_o`, so only one outstanding request.
- The response is held stable until `reg_rsp_ready_i`. A new request can be accepted in the cycle after the response handshake.
- A write's state effect is visible on `slot_busy_o` one cycle after accept.
- Reset asserted mid-operation: the pending response is dropped, all slots go IDLE, and the pointer returns to 0 immediately (async).

## Structure
- Use `top_addrmap_pkg` for `TOP_BASE_ADDR`, `TOP_SIZE`, `TOP_STATUS_NUM` and `state_e`. Derive slot addresses via `TOP_STATUS_BASE_ADDR(i)`.
- Block-local package `top_status_ctrl_pkg` holds `slot_idx_t` and `client_idx_t`.
- One sub-module, `top_status_rr_arb`: NumClients-way round-robin arbiter with grant-enable input, one-hot grant output and pointer update on accepted grant.

## Test plan
- **Allocate to saturation:** after reset, client0 and client1 request together. Cycle 0 grants client0 slot 0; cycle 1 grants client1 slot 1. A third request stays ungranted, and `slot_busy_o=2'b11`.
- **Round-robin fairness:** both clients request continuously while each granted slot is freed every cycle. Grants alternate 0,1,0,1.
- **Bus access:** write 1 to addr 0x4 → `slot_busy_o[1]=1` next cycle. Read 0x4 → rdata `0x1`, error 0.
- **Decode errors:** read 0x8, read 0x2 and write 0x9 each → `error=1`, `rdata=0`, no state change.
- **Collision:** bus write 0 to slot 0 in the same cycle as `free_i[0]` and a pending grant of slot 0 → grant suppressed, slot 0 IDLE next cycle, pointer unchanged.
- **Mid-operation reset:** assert `rst_ni` low with a response pending and slots BUSY → all outputs return to their reset values, and after release the first request is granted slot 0.
